// File: rtl/dsp_bus_pkg.sv
// Shared definitions for the DSP code-bus target.
// Contents: address window bases, control register bit positions, the bus
// FSM state type and the opcode word field layout used by the sequencer.
package dsp_bus_pkg;

    // iomem_addr[31:24] values selecting each window
    localparam logic [7:0] CODE_BASE = 8'h60;
    localparam logic [7:0] CTRL_BASE = 8'h62;

    // Control register bit positions
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_AUDIO_WR = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Opcode word layout: opcode[31:25] offset[24:20] chan[19:16] gain[15:0]
    localparam int OP_GAIN_LSB   = 0;
    localparam int OP_GAIN_W     = 16;
    localparam int OP_CHAN_LSB   = 16;
    localparam int OP_CHAN_W     = 4;
    localparam int OP_OFFSET_LSB = 20;
    localparam int OP_OFFSET_W   = 5;
    localparam int OP_OPCODE_LSB = 25;
    localparam int OP_OPCODE_W   = 7;

    function automatic logic [OP_OPCODE_W-1:0] op_opcode(input logic [31:0] word);
        return word[OP_OPCODE_LSB +: OP_OPCODE_W];
    endfunction

endpackage

// File: rtl/dsp_code_dpram.sv
// Code/coefficient RAM: one byte-enabled write port and two registered read
// ports (bus readback and sequencer fetch). Reads return the word held before
// a same-edge write. Storage is split into four byte-lane arrays so each lane
// has its own write enable.
// Ports:
//   clk, srst        clock, synchronous active-high reset (sequencer output only)
//   we_i, be_i       write enable, byte-lane enables
//   waddr_i, wdata_i write word address and data
//   bus_addr_i       bus read address  -> bus_rdata_o (registered, 0 if BUS_RD_EN=0)
//   seq_addr_i       sequencer address -> seq_rdata_o (registered)
module dsp_code_dpram #(
    parameter int AW        = 5,
    parameter bit BUS_RD_EN = 1'b1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] bus_addr_i,
    output logic [31:0]   bus_rdata_o,
    input  logic [AW-1:0] seq_addr_i,
    output logic [31:0]   seq_rdata_o
);
    localparam int DEPTH = 1 << AW;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] seq_q;

            always_ff @(posedge clk) begin
                if (we_i && be_i[gi]) begin
                    mem[waddr_i] <= wdata_i[8*gi +: 8];
                end
                if (srst) begin
                    seq_q <= 8'h00;
                end else begin
                    seq_q <= mem[seq_addr_i];
                end
            end
            assign seq_rdata_o[8*gi +: 8] = seq_q;

            if (BUS_RD_EN) begin : g_bus
                logic [7:0] bus_q;
                always_ff @(posedge clk) begin
                    bus_q <= mem[bus_addr_i];
                end
                assign bus_rdata_o[8*gi +: 8] = bus_q;
            end else begin : g_nobus
                logic unused_bus_addr;
                assign unused_bus_addr = ^bus_addr_i;
                assign bus_rdata_o[8*gi +: 8] = 8'h00;
            end
        end
    endgenerate

endmodule

// File: rtl/dsp_code_bus_target.sv
// iomem target for the DSP block: code RAM window (CODE_BASE) and control
// register window (CTRL_BASE). Each decoded access gets one registered
// one-cycle iomem_ready; the FSM then waits in ACK for valid to drop so a
// held request is never acknowledged twice.
// Optional feature macro: DSP_CODE_READBACK_EN. When defined, bus reads return
// RAM/ctrl contents; otherwise reads are acknowledged but return 0 and the bus
// read port of the RAM is not built.
// Ports:
//   ck, rst                       clock, synchronous active-high reset
//   iomem_valid/ready/wstrb/addr/wdata/rdata   initiator bus (wstrb==0 is a read)
//   code_addr, code_data          sequencer fetch port, 1-cycle registered
//   ctrl                          control register (bit0 run, bit1 audio writes)
module dsp_code_bus_target #(
    parameter int         CODE_AW   = 5,
    parameter logic [7:0] CODE_BASE = dsp_bus_pkg::CODE_BASE,
    parameter logic [7:0] CTRL_BASE = dsp_bus_pkg::CTRL_BASE
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    input  logic [CODE_AW-1:0] code_addr,
    output logic [31:0]        code_data,
    output logic [7:0]         ctrl
);
    import dsp_bus_pkg::*;

`ifdef DSP_CODE_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 latch_en;
    logic [CODE_AW-1:0]   widx_q;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 is_ctrl_q;
    logic                 oor_q;
    logic [7:0]           ctrl_q;
    logic [31:0]          bus_rdata;

    logic code_hit, ctrl_hit, hit, oor;
    logic ram_we, ctrl_we;
    logic unused_addr_bits;

    assign code_hit = (iomem_addr[31:24] == CODE_BASE);
    assign ctrl_hit = (iomem_addr[31:24] == CTRL_BASE);
    assign hit      = iomem_valid && (code_hit || ctrl_hit);
    // Code-window address bits above the RAM depth must be zero
    assign oor      = (iomem_addr[23:CODE_AW+2] != '0);
    assign unused_addr_bits = ^iomem_addr[1:0];

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    latch_en = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                ready_d = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!iomem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writes commit on the edge that leaves ACCESS; reset on that edge drops them.
    assign ram_we  = (state_q == ACCESS) && !is_ctrl_q && !oor_q && !rst;
    assign ctrl_we = (state_q == ACCESS) && is_ctrl_q && wstrb_q[0];

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            ctrl_q    <= 8'h00;
            widx_q    <= '0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            is_ctrl_q <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (latch_en) begin
                widx_q    <= iomem_addr[CODE_AW+1:2];
                wdata_q   <= iomem_wdata;
                wstrb_q   <= iomem_wstrb;
                is_ctrl_q <= ctrl_hit;
                oor_q     <= code_hit && oor;
            end
            if (ctrl_we) begin
                ctrl_q <= wdata_q[7:0];
            end
        end
    end

    dsp_code_dpram #(
        .AW        (CODE_AW),
        .BUS_RD_EN (READBACK)
    ) u_ram (
        .clk         (ck),
        .srst        (rst),
        .we_i        (ram_we),
        .be_i        (wstrb_q),
        .waddr_i     (widx_q),
        .wdata_i     (wdata_q),
        .bus_addr_i  (widx_q),
        .bus_rdata_o (bus_rdata),
        .seq_addr_i  (code_addr),
        .seq_rdata_o (code_data)
    );

    // Read data is formed from registered state and only shown with ready.
    // The RAM bus port registers mem[widx_q] on the same edge ready rises.
    always_comb begin
        iomem_rdata = 32'h0;
        if (READBACK && ready_q && (wstrb_q == 4'h0)) begin
            if (is_ctrl_q) begin
                iomem_rdata = {24'h0, ctrl_q};
            end else if (!oor_q) begin
                iomem_rdata = bus_rdata;
            end
        end
    end

    assign iomem_ready = ready_q;
    assign ctrl        = ctrl_q;

endmodule

// File: tb/tb_dsp_code_bus_target.sv
module tb_dsp_code_bus_target;

`ifdef DSP_CODE_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        ck = 1'b0;
    logic        rst;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [4:0]  code_addr;
    logic [31:0] code_data;
    logic [7:0]  ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  model_ctrl;

    always #5 ck = ~ck;

    dsp_code_bus_target dut (
        .ck          (ck),
        .rst         (rst),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .code_addr   (code_addr),
        .code_data   (code_data),
        .ctrl        (ctrl)
    );

    function automatic logic [31:0] exp_rd(input logic [31:0] v);
        return READBACK ? v : 32'h0;
    endfunction

    // Drives one request with valid held for 'hold' cycles. Reports the cycle
    // (1 = after the sampling edge) of the first ready, total ready pulses,
    // code_data at the ready cycle and one cycle later, and rdata with ready.
    task automatic do_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, output int first_n, output int pulses,
                          output logic [31:0] cd_rdy, output logic [31:0] cd_nxt,
                          output logic [31:0] rd);
        first_n = -1; pulses = 0; cd_rdy = 32'h0; cd_nxt = 32'h0; rd = 32'h0;
        @(posedge ck); #1;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        for (int n = 1; n <= hold; n++) begin
            @(posedge ck); @(negedge ck);
            if (first_n > 0 && n == first_n + 1) cd_nxt = code_data;
            if (iomem_ready) begin
                pulses++;
                if (first_n < 0) begin
                    first_n = n; cd_rdy = code_data; rd = iomem_rdata;
                end
            end
        end
        @(posedge ck); #1;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        @(posedge ck);
        $display("bus addr=%h wdata=%h wstrb=%b ack_cycle=%0d pulses=%0d rdata=%h",
                 a, d, s, first_n, pulses, rd);
    endtask

    task automatic fetch(input logic [4:0] a, output logic [31:0] v);
        @(posedge ck); #1 code_addr = a;
        @(posedge ck); @(negedge ck);
        v = code_data;
    endtask

    task automatic test_reset;
        rst = 1'b1; iomem_valid = 1'b0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
        iomem_wstrb = 4'h0; code_addr = 5'd0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        n_checks++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", iomem_ready); end
        n_checks++; if (iomem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", iomem_rdata); end
        n_checks++; if (code_data !== 32'h0) begin n_fail++; $display("FAIL reset_code_data got=%h exp=0", code_data); end
        n_checks++; if (ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", ctrl); end
        @(posedge ck); #1 rst = 1'b0;
        model_ctrl = 8'h00;
    endtask

    task automatic test_write_fetch;
        int fn, pc; logic [31:0] cdr, cdn, rd, v, e;
        do_bus(32'h6000_0000, 32'h8200_0003, 4'hF, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (fn !== 2) begin n_fail++; $display("FAIL wr_latency got=%0d exp=2", fn); end
        n_checks++; if (pc !== 1) begin n_fail++; $display("FAIL wr_pulses got=%0d exp=1", pc); end
        fetch(5'd0, v);
        n_checks++; if (v !== 32'h8200_0003) begin n_fail++; $display("FAIL fetch_w0 got=%h exp=82000003", v); end
        exp_q.push_back(exp_rd(32'h8200_0003));
        do_bus(32'h6000_0000, 32'h0, 4'h0, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (fn !== 2) begin n_fail++; $display("FAIL rd_latency got=%0d exp=2", fn); end
        e = exp_q.pop_front();
        n_checks++; if (rd !== e) begin n_fail++; $display("FAIL rd_w0 got=%h exp=%h", rd, e); end
    endtask

    task automatic test_ctrl;
        int fn, pc; logic [31:0] cdr, cdn, rd, e;
        do_bus(32'h6200_0000, 32'h0000_0003, 4'hF, 4, fn, pc, cdr, cdn, rd);
        model_ctrl = 8'h03;
        n_checks++; if (ctrl !== model_ctrl) begin n_fail++; $display("FAIL ctrl_write got=%h exp=%h", ctrl, model_ctrl); end
        do_bus(32'h6200_0000, 32'hFFFF_FF00, 4'b0010, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (ctrl !== 8'h03) begin n_fail++; $display("FAIL ctrl_lane1 got=%h exp=03", ctrl); end
        exp_q.push_back(exp_rd({24'h0, model_ctrl}));
        do_bus(32'h6200_0000, 32'h0, 4'h0, 4, fn, pc, cdr, cdn, rd);
        e = exp_q.pop_front();
        n_checks++; if (rd !== e) begin n_fail++; $display("FAIL ctrl_read got=%h exp=%h", rd, e); end
    endtask

    task automatic test_partial;
        int fn, pc; logic [31:0] cdr, cdn, rd, v, e;
        do_bus(32'h6000_0004, 32'h1122_3344, 4'hF, 4, fn, pc, cdr, cdn, rd);
        do_bus(32'h6000_0004, 32'hAABB_CCDD, 4'b0101, 4, fn, pc, cdr, cdn, rd);
        fetch(5'd1, v);
        n_checks++; if (v !== 32'h11BB_33DD) begin n_fail++; $display("FAIL partial_fetch got=%h exp=11bb33dd", v); end
        exp_q.push_back(exp_rd(32'h11BB_33DD));
        do_bus(32'h6000_0004, 32'h0, 4'h0, 4, fn, pc, cdr, cdn, rd);
        e = exp_q.pop_front();
        n_checks++; if (rd !== e) begin n_fail++; $display("FAIL partial_read got=%h exp=%h", rd, e); end
    endtask

    task automatic test_miss;
        int fn, pc; logic [31:0] cdr, cdn, rd, v, e;
        do_bus(32'h6400_0000, 32'hFFFF_FFFF, 4'hF, 20, fn, pc, cdr, cdn, rd);
        n_checks++; if (pc !== 0) begin n_fail++; $display("FAIL miss_ready got=%0d exp=0", pc); end
        n_checks++; if (ctrl !== model_ctrl) begin n_fail++; $display("FAIL miss_ctrl got=%h exp=%h", ctrl, model_ctrl); end
        do_bus(32'h6000_0400, 32'h1234_5678, 4'hF, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (fn !== 2) begin n_fail++; $display("FAIL oor_ack got=%0d exp=2", fn); end
        fetch(5'd0, v);
        n_checks++; if (v !== 32'h8200_0003) begin n_fail++; $display("FAIL oor_ram got=%h exp=82000003", v); end
        exp_q.push_back(32'h0);
        do_bus(32'h6000_0400, 32'h0, 4'h0, 4, fn, pc, cdr, cdn, rd);
        e = exp_q.pop_front();
        n_checks++; if (rd !== e || fn !== 2) begin n_fail++; $display("FAIL oor_read got=%h/%0d exp=%h/2", rd, fn, e); end
    endtask

    task automatic test_hold;
        int fn, pc; logic [31:0] cdr, cdn, rd, v;
        do_bus(32'h6000_000C, 32'h0C0C_0C0C, 4'hF, 10, fn, pc, cdr, cdn, rd);
        n_checks++; if (pc !== 1) begin n_fail++; $display("FAIL hold_pulses got=%0d exp=1", pc); end
        do_bus(32'h6000_0010, 32'h1010_1010, 4'hF, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (fn !== 2) begin n_fail++; $display("FAIL hold_next_ack got=%0d exp=2", fn); end
        fetch(5'd4, v);
        n_checks++; if (v !== 32'h1010_1010) begin n_fail++; $display("FAIL hold_next_data got=%h exp=10101010", v); end
    endtask

    task automatic test_reset_mid;
        int fn, pc; logic [31:0] cdr, cdn, rd, v;
        int seen;
        do_bus(32'h6000_0008, 32'h55AA_55AA, 4'hF, 4, fn, pc, cdr, cdn, rd);
        @(posedge ck); #1;
        iomem_valid = 1'b1; iomem_addr = 32'h6000_0008; iomem_wdata = 32'hDEAD_BEEF; iomem_wstrb = 4'hF;
        @(posedge ck); #1 rst = 1'b1;
        @(posedge ck); #1 rst = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        model_ctrl = 8'h00;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge ck);
            if (iomem_ready) seen++;
        end
        $display("bus addr=60000008 wdata=deadbeef wstrb=1111 reset mid-access ready_pulses=%0d", seen);
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_ready got=%0d exp=0", seen); end
        n_checks++; if (ctrl !== model_ctrl) begin n_fail++; $display("FAIL rstmid_ctrl got=%h exp=00", ctrl); end
        fetch(5'd2, v);
        n_checks++; if (v !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rstmid_word2 got=%h exp=55aa55aa", v); end
    endtask

    task automatic test_rbw;
        int fn, pc; logic [31:0] cdr, cdn, rd;
        code_addr = 5'd2;
        do_bus(32'h6000_0008, 32'hCAFE_F00D, 4'hF, 4, fn, pc, cdr, cdn, rd);
        n_checks++; if (cdr !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rbw_old got=%h exp=55aa55aa", cdr); end
        n_checks++; if (cdn !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rbw_new got=%h exp=cafef00d", cdn); end
    endtask

    initial begin
        test_reset();
        test_write_fetch();
        test_ctrl();
        test_partial();
        test_miss();
        test_hold();
        test_reset_mid();
        test_rbw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
